// File: rtl/counter_check_pkg.sv
// counter_check_pkg: shared state encoding, default parameters and saturating increment.
package counter_check_pkg;
   localparam int DEF_WIDTH         = 5;
   localparam int DEF_SETTLE_CYCLES = 2;
   localparam int DEF_NUM_SAMPLES   = 50;
   localparam int DEF_STEP          = 1;
   localparam int DEF_CNT_W         = 8;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   // Increments v unless it already holds the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max;
      max = 32'hFFFF_FFFF >> (32 - w);
      return (v == max) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: CNT_W-bit counter that sticks at all-ones; clr wins over inc.
module sat_counter
   import counter_check_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else if (clr) q <= '0;
      else if (inc) q <= CNT_W'(sat_inc(32'(q), CNT_W));
   end
endmodule

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: compares golden vs netlist counter samples, checks golden stepping,
// counts failures and captures the first one.
module counter_stream_checker
   import counter_check_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES,
   parameter int STEP          = DEF_STEP,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sample_en,
   input  logic             resync,
   input  logic [WIDTH-1:0] golden,
   input  logic [WIDTH-1:0] dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] seq_err_cnt,
   output logic [CNT_W-1:0] sample_idx,
   output logic             first_err_valid,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_golden,
   output logic [WIDTH-1:0] first_err_dut
);
   state_t           state, state_d;
   logic [CNT_W-1:0] settle_cnt;
   logic [WIDTH-1:0] prev_golden, exp_golden;
   logic             seq_armed, resync_pend;
   logic             take, mis, seq, fail, last;

   assign exp_golden = prev_golden + WIDTH'(STEP);
   assign take = sample_en && state == CHECK && !start;
   assign mis  = golden != dut;
   // A pending or coincident resync disarms the step check for exactly one sample.
   assign seq  = seq_armed && !resync && !resync_pend && golden != exp_golden;
   assign fail = take && (mis || seq);
   assign last = take && 32'(sample_idx) + 1 == NUM_SAMPLES;

   always_comb begin
      state_d = state;
      if (start) state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      else if (state == SETTLE && 32'(settle_cnt) + 1 >= SETTLE_CYCLES) state_d = CHECK;
      else if (last) state_d = DONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         settle_cnt       <= '0;
         prev_golden      <= '0;
         seq_armed        <= 1'b0;
         resync_pend      <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         sample_idx       <= '0;
         first_err_valid  <= 1'b0;
         first_err_idx    <= '0;
         first_err_golden <= '0;
         first_err_dut    <= '0;
      end else begin
         state       <= state_d;
         busy        <= state_d == SETTLE || state_d == CHECK;
         done        <= state_d == DONE;
         pass        <= state_d == DONE && !first_err_valid && !fail;
         settle_cnt  <= (state == SETTLE && !start) ? settle_cnt + CNT_W'(1) : '0;
         resync_pend <= !start && !take && (resync || resync_pend);
         if (start) begin
            sample_idx       <= '0;
            seq_armed        <= 1'b0;
            first_err_valid  <= 1'b0;
            first_err_idx    <= '0;
            first_err_golden <= '0;
            first_err_dut    <= '0;
         end else if (take) begin
            sample_idx  <= CNT_W'(sat_inc(32'(sample_idx), CNT_W));
            prev_golden <= golden;
            seq_armed   <= 1'b1;
            if (fail && !first_err_valid) begin
               first_err_valid  <= 1'b1;
               first_err_idx    <= sample_idx;
               first_err_golden <= golden;
               first_err_dut    <= dut;
            end
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_mismatch (
      .clk(clk), .reset(reset), .clr(start), .inc(take && mis), .q(mismatch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_seq_err (
      .clk(clk), .reset(reset), .clr(start), .inc(take && seq), .q(seq_err_cnt)
   );
endmodule

// File: tb/tb_counter_stream_checker.sv
// tb_counter_stream_checker: scenario tasks with a queue scoreboard against a reference model;
// a second 3-bit-counter instance shares the stimulus for the saturation scenario.
module tb_counter_stream_checker;
   import counter_check_pkg::*;

   localparam int STEP_TB = 1;

   logic       clk = 0, reset = 0, start = 0, sample_en = 0, resync = 0;
   logic [4:0] golden = 0, dut = 0;
   logic       busy, done, pass, fev;
   logic [7:0] mis_cnt, seq_cnt, idx, fe_idx;
   logic [4:0] fe_g, fe_d;
   logic       s_busy, s_done, s_pass, s_fev;
   logic [2:0] s_mis, s_seq, s_idx, s_fe_idx;
   logic [4:0] s_fe_g, s_fe_d;

   int checks = 0, failures = 0;

   typedef struct {
      int   idx;
      int   mis;
      int   seq;
      logic busy;
      logic done;
      logic pass;
   } exp_t;
   exp_t sb[$];

   int m_idx, m_mis, m_seq, m_prev;
   bit m_armed, m_check, m_done, m_fail;

   counter_stream_checker u_dut (
      .clk(clk), .reset(reset), .start(start), .sample_en(sample_en), .resync(resync),
      .golden(golden), .dut(dut), .busy(busy), .done(done), .pass(pass),
      .mismatch_cnt(mis_cnt), .seq_err_cnt(seq_cnt), .sample_idx(idx),
      .first_err_valid(fev), .first_err_idx(fe_idx), .first_err_golden(fe_g), .first_err_dut(fe_d)
   );

   counter_stream_checker #(.CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .start(start), .sample_en(sample_en), .resync(resync),
      .golden(golden), .dut(dut), .busy(s_busy), .done(s_done), .pass(s_pass),
      .mismatch_cnt(s_mis), .seq_err_cnt(s_seq), .sample_idx(s_idx),
      .first_err_valid(s_fev), .first_err_idx(s_fe_idx), .first_err_golden(s_fe_g), .first_err_dut(s_fe_d)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      m_idx = 0; m_mis = 0; m_seq = 0; m_armed = 0; m_check = 0; m_done = 0; m_fail = 0;
   endtask

   task automatic drive_sample(input logic [4:0] g, input logic [4:0] d, input logic rs);
      exp_t e;
      bit   mis, seq;
      sample_en = 1; golden = g; dut = d; resync = rs;
      if (m_check) begin
         mis = g != d;
         seq = m_armed && !rs && int'(g) != (m_prev + STEP_TB) % 32;
         m_idx++;
         if (mis) m_mis = (m_mis < 255) ? m_mis + 1 : 255;
         if (seq) m_seq = (m_seq < 255) ? m_seq + 1 : 255;
         m_fail = m_fail || mis || seq;
         m_prev = int'(g);
         m_armed = 1;
         if (m_idx == 50) begin m_done = 1; m_check = 0; end
      end
      e = '{m_idx, m_mis, m_seq, m_check, m_done, m_done && !m_fail};
      sb.push_back(e);
      tick;
      sample_en = 0; resync = 0;
      e = sb.pop_front();
      checks++;
      if (idx !== 8'(e.idx)) begin failures++; $display("FAIL sample_idx got=%0d exp=%0d", idx, e.idx); end
      checks++;
      if (mis_cnt !== 8'(e.mis)) begin failures++; $display("FAIL mismatch_cnt got=%0d exp=%0d at idx %0d", mis_cnt, e.mis, e.idx); end
      checks++;
      if (seq_cnt !== 8'(e.seq)) begin failures++; $display("FAIL seq_err_cnt got=%0d exp=%0d at idx %0d", seq_cnt, e.seq, e.idx); end
      checks++;
      if ({busy, done, pass} !== {e.busy, e.done, e.pass})
         begin failures++; $display("FAIL busy_done_pass got=%b%b%b exp=%b%b%b", busy, done, pass, e.busy, e.done, e.pass); end
   endtask

   task automatic pulse_resync;
      resync = 1;
      tick;
      resync = 0;
      m_armed = 0;
   endtask

   task automatic do_start(input bit collide);
      start = 1;
      if (collide) begin sample_en = 1; golden = 3; dut = 4; end
      tick;
      start = 0;
      model_clear;
      checks++;
      if ({busy, done, idx, mis_cnt, seq_cnt, fev} !== {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0})
         begin failures++; $display("FAIL start_clear busy=%b done=%b idx=%0d mis=%0d seq=%0d fev=%b exp 1 0 0 0 0 0", busy, done, idx, mis_cnt, seq_cnt, fev); end
      checks++;
      if (u_dut.state !== SETTLE) begin failures++; $display("FAIL start_state got=%0d exp=%0d", u_dut.state, SETTLE); end
      sample_en = 1; golden = 9; dut = 1;
      tick;
      checks++;
      if (idx !== 8'd0 || u_dut.state !== SETTLE)
         begin failures++; $display("FAIL settle_1 idx=%0d state=%0d exp idx=0 state=%0d", idx, u_dut.state, SETTLE); end
      tick;
      sample_en = 0;
      checks++;
      if (idx !== 8'd0 || mis_cnt !== 8'd0 || u_dut.state !== CHECK)
         begin failures++; $display("FAIL settle_2 idx=%0d mis=%0d state=%0d exp 0 0 %0d", idx, mis_cnt, u_dut.state, CHECK); end
      m_check = 1;
   endtask

   task automatic test_reset;
      reset = 0;
      repeat (3) tick;
      checks++;
      if ({busy, done, pass, mis_cnt, seq_cnt, idx, fev, fe_idx, fe_g, fe_d} !== '0)
         begin failures++; $display("FAIL reset_outputs got busy=%b done=%b pass=%b mis=%0d seq=%0d idx=%0d fev=%b exp all 0", busy, done, pass, mis_cnt, seq_cnt, idx, fev); end
      checks++;
      if ({s_busy, s_done, s_pass, s_mis, s_seq, s_idx, s_fev, s_fe_idx, s_fe_g, s_fe_d} !== '0)
         begin failures++; $display("FAIL reset_outputs_sat got mis=%0d idx=%0d exp all 0", s_mis, s_idx); end
      reset = 1;
      model_clear;
      tick;
   endtask

   task automatic test_idle_ignore;
      drive_sample(5'd4, 5'd6, 1'b0);
      drive_sample(5'd7, 5'd7, 1'b0);
   endtask

   task automatic test_clean;
      do_start(0);
      for (int i = 0; i < 50; i++) drive_sample(5'(i), 5'(i), 1'b0);
      checks++;
      if ({done, pass, fev} !== 3'b110) begin failures++; $display("FAIL clean_end done=%b pass=%b fev=%b exp 1 1 0", done, pass, fev); end
      drive_sample(5'd5, 5'd9, 1'b0);
   endtask

   task automatic test_mismatch;
      logic [4:0] d;
      do_start(0);
      for (int i = 0; i < 50; i++) begin
         d = (i == 7) ? 5'd5 : (i == 20) ? 5'd3 : 5'(i);
         drive_sample(5'(i), d, 1'b0);
         if (i == 7 || i == 49) begin
            checks++;
            if ({fev, fe_idx, fe_g, fe_d} !== {1'b1, 8'd7, 5'd7, 5'd5})
               begin failures++; $display("FAIL first_err at %0d got v=%b idx=%0d g=%0d d=%0d exp 1 7 7 5", i, fev, fe_idx, fe_g, fe_d); end
         end
      end
      checks++;
      if ({done, pass, mis_cnt, seq_cnt} !== {1'b1, 1'b0, 8'd2, 8'd0})
         begin failures++; $display("FAIL mismatch_end done=%b pass=%b mis=%0d seq=%0d exp 1 0 2 0", done, pass, mis_cnt, seq_cnt); end
   endtask

   task automatic test_seq_resync;
      int seq_a[5] = '{8, 9, 10, 12, 13};
      do_start(0);
      foreach (seq_a[k]) drive_sample(5'(seq_a[k]), 5'(seq_a[k]), 1'b0);
      checks++;
      if ({seq_cnt, mis_cnt, fe_idx} !== {8'd1, 8'd0, 8'd3})
         begin failures++; $display("FAIL seq_err got seq=%0d mis=%0d fe_idx=%0d exp 1 0 3", seq_cnt, mis_cnt, fe_idx); end
      do_start(1);
      drive_sample(5'd10, 5'd10, 1'b0);
      pulse_resync;
      drive_sample(5'd12, 5'd12, 1'b0);
      drive_sample(5'd13, 5'd13, 1'b0);
      drive_sample(5'd20, 5'd20, 1'b1);
      drive_sample(5'd21, 5'd21, 1'b0);
      checks++;
      if ({seq_cnt, fev} !== {8'd0, 1'b0}) begin failures++; $display("FAIL resync got seq=%0d fev=%b exp 0 0", seq_cnt, fev); end
   endtask

   task automatic test_reset_midrun;
      do_start(0);
      for (int i = 0; i < 25; i++) drive_sample(5'(i), (i == 3) ? 5'd0 : 5'(i), 1'b0);
      #2 reset = 0;
      #1;
      checks++;
      if ({busy, done, pass, mis_cnt, seq_cnt, idx, fev, fe_idx, fe_g, fe_d} !== '0)
         begin failures++; $display("FAIL async_reset got busy=%b mis=%0d idx=%0d fev=%b fe_idx=%0d exp all 0", busy, mis_cnt, idx, fev, fe_idx); end
      model_clear;
      @(posedge clk);
      #1 reset = 1;
      drive_sample(5'd4, 5'd6, 1'b0);
      do_start(0);
      for (int i = 0; i < 5; i++) drive_sample(5'(i), ~5'(i), 1'b0);
      do_start(0);
      drive_sample(5'd1, 5'd1, 1'b0);
   endtask

   task automatic test_saturation;
      do_start(0);
      for (int i = 0; i < 20; i++) drive_sample(5'(i), ~5'(i), 1'b0);
      checks++;
      if ({s_mis, s_idx, s_seq} !== {3'd7, 3'd7, 3'd0})
         begin failures++; $display("FAIL saturation got mis=%0d idx=%0d seq=%0d exp 7 7 0", s_mis, s_idx, s_seq); end
   endtask

   initial begin
      test_reset;
      test_idle_ignore;
      test_clean;
      test_mismatch;
      test_seq_resync;
      test_reset_midrun;
      test_saturation;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
- Synthesizable result checker directly downstream of the 5-bit up-counter under test.
- Consumes the golden counter value and the post-route netlist counter value, one sample per strobe, and compares them.
- Also checks that the golden stream advances by a fixed step, wrapping modulo 2^WIDTH.
- Accumulates mismatch and sequence-error counts, captures the first failure, and raises done/pass after a programmed number of samples.

Parameters:
- WIDTH, 5: counter value width.
- SETTLE_CYCLES, 2: clocks ignored after start, before checking begins.
- NUM_SAMPLES, 50: samples checked per run.
- STEP, 1: expected golden increment per sample, modulo 2^WIDTH.
- CNT_W, 8: width of the error counters and sample index.

Ports:
- clk  in  1  sampling clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse; (re)starts a run.
- sample_en  in  1  strobe; golden/dut are valid this cycle.
- resync  in  1  pulse; the next sample is not sequence-checked (counter was reset upstream).
- golden  in  WIDTH  reference counter value.
- dut  in  WIDTH  netlist counter value.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high.
- mismatch_cnt  out  CNT_W  count of golden != dut; saturating.
- seq_err_cnt  out  CNT_W  count of golden step violations; saturating.
- sample_idx  out  CNT_W  samples consumed this run.
- first_err_valid  out  1  first failure has been captured.
- first_err_idx  out  CNT_W  sample_idx of the first failure.
- first_err_golden  out  WIDTH  golden value at the first failure.
- first_err_dut  out  WIDTH  dut value at the first failure.

Behaviour:
- Reset: all outputs 0; state IDLE; prev_golden = 0; seq_armed = 0.
- Reset mid-run: abort immediately to the reset values above.
- All outputs are registered. A sample accepted on edge N is reflected in the counters after edge N.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: samples are ignored. start moves to SETTLE.
- start in any state: clears counters, sample_idx, first_err_* and seq_armed, then enters SETTLE. start has priority over sample_en in the same cycle.
- SETTLE: wait exactly SETTLE_CYCLES clocks, ignoring sample_en, then enter CHECK. If SETTLE_CYCLES = 0, go straight to CHECK on the next edge.
- CHECK, on each sample_en:
  - sample_idx increments.
  - mismatch = (golden != dut).
  - seq_err = seq_armed && (golden != prev_golden + STEP mod 2^WIDTH).
  - prev_golden <= golden; seq_armed <= 1.
  - Wrap case: prev_golden = 31 with STEP = 1 expects golden = 0, and this is not an error.
- Counter update: each counter increments on its own condition. A sample can bump both counters. Both saturate at 2^CNT_W-1.
- First failure: on the first sample with mismatch or seq_err, latch first_err_* and set first_err_valid. Later failures do not overwrite it.
- resync: on the sample coinciding with resync, or on the first sample after it, seq_armed is treated as 0. prev_golden still updates. The mismatch check is unaffected.
- End of run: when sample_idx reaches NUM_SAMPLES on a sample edge, go to DONE on that edge. In DONE, pass = (mismatch_cnt == 0 && seq_err_cnt == 0). DONE holds until start or reset.
- sample_en outside CHECK has no effect.

Decomposition:
- Package counter_check_pkg holds:
  - the state_t enum (IDLE, SETTLE, CHECK, DONE);
  - the saturating-increment function;
  - default parameter constants.
- One sub-module, sat_counter, is the natural split: parameterized CNT_W saturating counter with inc and clr inputs, instantiated for mismatch_cnt and seq_err_cnt.
- The FSM, comparison and first-error capture stay in the top module.

Test Plan:
- Clean run: reset low 3 clocks, then high; start; after 2 clocks feed 50 samples with golden = dut = 0,1,...,31,0,...,17. Required: done = 1 and pass = 1 on the edge after the 50th sample; both counts 0; first_err_valid = 0.
- Single mismatch at sample 7: golden = 7, dut = 5. Required: mismatch_cnt = 1, seq_err_cnt = 0, first_err_idx = 7, first_err_golden = 7, first_err_dut = 5, pass = 0. A later mismatch at sample 20 does not change first_err_*.
- Sequence error: golden jumps 10 -> 12 with dut equal. Required: seq_err_cnt = 1, mismatch_cnt = 0. Repeat with resync asserted before the 12: no error.
- Saturation: with CNT_W = 3, run 20 mismatching samples. Required: mismatch_cnt holds at 7.
- Reset and restart: assert reset at sample 25 of a failing run. Required: all outputs 0 at once. Then start mid-CHECK on another run: counters clear and SETTLE lasts 2 clocks. Samples during SETTLE and in IDLE do not change sample_idx.
- Start/sample collision: start and sample_en high in the same cycle. Required: the sample is ignored; sample_idx = 0; state = SETTLE.
